// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake, issues
// IF/ID values (instruction, PC+4, PC+8) and applies decode redirects after the delay slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic [31:0] branchtarget,
    input  logic [31:0] jumptarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instructionout,
    output logic [31:0] delayout,
    output logic [31:0] delay2out,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] delay2_q, delay2_d;
    logic        valid_q, valid_d;
    logic        redir_pending_q, redir_pending_d;
    logic [31:0] redir_target_q, redir_target_d;
    logic [31:0] skid_data_q, skid_data_d;

    logic        redir_now;
    logic [31:0] redir_now_target;
    logic [31:0] next_pc;
    logic        issue;
    logic [31:0] issue_word;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it
        // unassigned and no latch is inferred; combinational logic uses blocking '='.
        state_d         = state_q;
        pc_d            = pc_q;
        req_d           = req_q;
        instr_d         = instr_q;
        delay_d         = delay_q;
        delay2_d        = delay2_q;
        valid_d         = valid_q;
        redir_pending_d = redir_pending_q;
        redir_target_d  = redir_target_q;
        skid_data_d     = skid_data_q;

        // Decode only hands us a redirect in a cycle it is not stalled; jump wins.
        redir_now        = !stall && (branch || jump);
        redir_now_target = {(jump ? jumptarget[31:2] : branchtarget[31:2]), 2'b00};
        next_pc          = redir_now       ? redir_now_target :
                           redir_pending_q ? redir_target_q   : pc_q + 32'd4;

        issue      = !stall && ((state_q == REQ && imem_ack) || state_q == HOLD);
        issue_word = (state_q == HOLD) ? skid_data_q : imem_rdata;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
            end
            REQ: begin
                if (imem_ack && stall) begin
                    skid_data_d = imem_rdata;
                    req_d       = 1'b0;
                    state_d     = HOLD;
                end else if (!imem_ack && !stall) begin
                    instr_d = NOP_INST;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // The instruction issuing now is the delay slot of any outstanding redirect.
        if (issue) begin
            instr_d         = issue_word;
            delay_d         = pc_q + 32'd4;
            delay2_d        = pc_q + 32'd8;
            valid_d         = 1'b1;
            pc_d            = next_pc;
            redir_pending_d = 1'b0;
        end else if (redir_now) begin
            redir_pending_d = 1'b1;
            redir_target_d  = redir_now_target;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            pc_q            <= RESET_PC;
            req_q           <= 1'b0;
            instr_q         <= NOP_INST;
            delay_q         <= 32'd0;
            delay2_q        <= 32'd0;
            valid_q         <= 1'b0;
            redir_pending_q <= 1'b0;
            redir_target_q  <= 32'd0;
            skid_data_q     <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_q           <= req_d;
            instr_q         <= instr_d;
            delay_q         <= delay_d;
            delay2_q        <= delay2_d;
            valid_q         <= valid_d;
            redir_pending_q <= redir_pending_d;
            redir_target_q  <= redir_target_d;
            skid_data_q     <= skid_data_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign instructionout = instr_q;
    assign delayout       = delay_q;
    assign delay2out      = delay2_q;
    assign fetch_valid    = valid_q;

endmodule
